// File: rtl/mls_pkg.sv
// Constants and types shared by the 8-bit maximal-length sequence generator and checker.
// Tap positions 8,6,5,4 of the history map to bits 7,5,4,3 of MLS_TAPS.
package mls_pkg;

  localparam int MLS_LEN = 8;
  localparam logic [MLS_LEN-1:0] MLS_TAPS = 8'b1011_1000;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mls_state_e;

endpackage

// File: rtl/mls_checker_if.sv
// Serial receive bundle between the bit source and the MLS checker.
// The master drives data and control; the checker (slave) returns lock and error status.
interface mls_checker_if #(
  parameter int ERR_W = 16
);

  logic             din;
  logic             din_valid;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din, din_valid, clear_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  din, din_valid, clear_err,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/mls_predict.sv
// Combinational next-bit predictor for the x8+x6+x5+x4 recurrence.
// hist[k-1] holds H[k]; H[1] is the newest bit.
module mls_predict
  import mls_pkg::*;
(
  input  logic [MLS_LEN-1:0] hist,
  output logic               pred,
  output logic               all_zero
);

  assign pred     = ^(hist & MLS_TAPS);
  assign all_zero = ~|hist;

endmodule

// File: rtl/mls_checker.sv
// Receive-side MLS checker: self-synchronises to the stream, then free-runs a local
// predictor and counts bit errors with a saturating counter.
module mls_checker
  import mls_pkg::*;
#(
  parameter int LOCK_THRESH   = 16,
  parameter int UNLOCK_THRESH = 4,
  parameter int ERR_W         = 16
) (
  input logic          clk,
  input logic          reset,
  mls_checker_if.slave bus
);

  logic [MLS_LEN-1:0] hist;
  logic [3:0]         fill_cnt;
  logic [7:0]         match_cnt;
  logic [3:0]         miss_cnt;
  mls_state_e         state;
  logic               locked;
  logic               err_pulse;
  logic [ERR_W-1:0]   err_count;

  logic               pred;
  logic               hist_zero;
  logic               filled;
  logic               miss;
  logic               counted_err;
  logic [7:0]         match_next;
  logic [3:0]         miss_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  mls_predict u_predict (
    .hist     (hist),
    .pred     (pred),
    .all_zero (hist_zero)
  );

  assign filled      = (fill_cnt == 4'(MLS_LEN));
  assign miss        = (bus.din != pred);
  assign match_next  = match_cnt + 8'd1;
  assign miss_next   = miss_cnt + 4'd1;
  assign counted_err = bus.din_valid && (state == LOCKED) && miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      state     <= SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.din_valid) begin
        if (state == SEARCH) begin
          hist <= {hist[MLS_LEN-2:0], bus.din};
          if (!filled) begin
            fill_cnt <= fill_cnt + 4'd1;
          // An all-zero history is the LFSR lockup state and must never count as a match.
          end else if (!hist_zero && !miss) begin
            if (match_next == 8'(LOCK_THRESH)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_next;
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          // Free-run on the prediction so isolated line errors do not corrupt the history.
          hist <= {hist[MLS_LEN-2:0], pred};
          if (miss) begin
            err_pulse <= 1'b1;
            if (miss_next == 4'(UNLOCK_THRESH)) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_next;
            end
          end else begin
            miss_cnt <= '0;
          end
        end
      end
    end
  end

  // Clear takes effect before a coincident increment, so clear plus error yields one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (counted_err) begin
      err_count <= sat_inc(bus.clear_err ? '0 : err_count);
    end else if (bus.clear_err) begin
      err_count <= '0;
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_mls_checker.sv
// Directed bench for mls_checker: two instances (16-bit and 2-bit error counters) share
// one stimulus stream built from the x8+x6+x5+x4 recurrence seeded with 8'h01.
module tb_mls_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mls_checker_if #(.ERR_W(16)) bus16 ();
  mls_checker_if #(.ERR_W(2))  bus2 ();

  mls_checker #(.LOCK_THRESH(16), .UNLOCK_THRESH(4), .ERR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  mls_checker #(.LOCK_THRESH(16), .UNLOCK_THRESH(4), .ERR_W(2)) dut_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic s [1:1600];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on both instances, then sample 1 time unit after the edge.
  task automatic send(input logic b, input logic v, input logic clr);
    bus16.din       = b;
    bus16.din_valid = v;
    bus16.clear_err = clr;
    bus2.din        = b;
    bus2.din_valid  = v;
    bus2.clear_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int idx, input logic flip);
    send(s[idx] ^ flip, 1'b1, 1'b0);
  endtask

  initial begin
    int pulses;
    int lk;
    int vn;
    int iters;
    int early;
    logic v;

    // Seed 8'h01 emitted oldest first, then the generator recurrence.
    for (int i = 1; i <= 7; i++) s[i] = 1'b0;
    s[8] = 1'b1;
    for (int i = 9; i <= 1600; i++) s[i] = s[i-8] ^ s[i-6] ^ s[i-5] ^ s[i-4];

    reset = 1'b1;
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("rst_locked",    16'(bus16.locked),    16'd0);
    check("rst_err_pulse", 16'(bus16.err_pulse), 16'd0);
    check("rst_err_count", bus16.err_count,      16'd0);
    check("rst_err_w2",    16'(bus2.err_count),  16'd0);
    reset = 1'b0;

    // Clean acquisition: 8 fill bits plus 16 matches.
    for (int i = 1; i <= 23; i++) send_bit(i, 1'b0);
    check("lock_pre24", 16'(bus16.locked), 16'd0);
    send_bit(24, 1'b0);
    check("lock_at24", 16'(bus16.locked), 16'd1);

    pulses = 0;
    for (int i = 25; i <= 1000; i++) begin
      send_bit(i, 1'b0);
      if (bus16.err_pulse) pulses++;
    end
    check("clean_pulses", 16'(pulses),      16'd0);
    check("clean_errcnt", bus16.err_count,  16'd0);
    check("clean_locked", 16'(bus16.locked), 16'd1);

    // Isolated flip.
    for (int i = 1001; i <= 1299; i++) send_bit(i, 1'b0);
    send_bit(1300, 1'b1);
    check("iso_pulse",  16'(bus16.err_pulse), 16'd1);
    check("iso_errcnt", bus16.err_count,      16'd1);
    check("iso_locked", 16'(bus16.locked),    16'd1);
    send_bit(1301, 1'b0);
    check("iso_pulse_off", 16'(bus16.err_pulse), 16'd0);
    pulses = 0;
    for (int i = 1302; i <= 1349; i++) begin
      send_bit(i, 1'b0);
      if (bus16.err_pulse) pulses++;
    end
    check("iso_no_more", 16'(pulses),     16'd0);
    check("iso_errcnt2", bus16.err_count, 16'd1);

    send(s[1350], 1'b1, 1'b1);
    check("clr_errcnt", bus16.err_count,     16'd0);
    check("clr_err_w2", 16'(bus2.err_count), 16'd0);
    check("clr_locked", 16'(bus16.locked),   16'd1);

    // Four consecutive flips drop lock.
    for (int i = 1351; i <= 1399; i++) send_bit(i, 1'b0);
    for (int i = 1400; i <= 1402; i++) send_bit(i, 1'b1);
    check("burst3_locked", 16'(bus16.locked), 16'd1);
    send_bit(1403, 1'b1);
    check("burst4_locked", 16'(bus16.locked),   16'd0);
    check("burst4_errcnt", bus16.err_count,     16'd4);
    check("burst4_err_w2", 16'(bus2.err_count), 16'd3);
    for (int i = 1404; i <= 1426; i++) send_bit(i, 1'b0);
    check("relock_pre", 16'(bus16.locked), 16'd0);
    send_bit(1427, 1'b0);
    check("relock_at24", 16'(bus16.locked), 16'd1);

    // Saturation on the 2-bit counter and clear coincident with an error.
    send_bit(1428, 1'b0);
    send_bit(1429, 1'b0);
    send(s[1430], 1'b1, 1'b1);
    for (int i = 1431; i <= 1489; i++) begin
      send_bit(i, (i % 10) == 0);
      if (i == 1450) check("sat_w2_2", 16'(bus2.err_count), 16'd2);
      if (i == 1460) check("sat_w2_3", 16'(bus2.err_count), 16'd3);
      if (i == 1470) check("sat_w2_4", 16'(bus2.err_count), 16'd3);
    end
    check("sat_errcnt16", bus16.err_count,     16'd5);
    check("sat_err_w2",   16'(bus2.err_count), 16'd3);
    check("sat_locked",   16'(bus16.locked),   16'd1);
    send(~s[1490], 1'b1, 1'b1);
    check("clrerr_errcnt16", bus16.err_count,      16'd1);
    check("clrerr_err_w2",   16'(bus2.err_count),  16'd1);
    check("clrerr_pulse",    16'(bus16.err_pulse), 16'd1);

    // All-zero input never locks.
    reset = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    lk = 0;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (bus16.locked) lk++;
      if (bus16.err_pulse) pulses++;
    end
    check("zero_locked", 16'(lk),          16'd0);
    check("zero_pulses", 16'(pulses),      16'd0);
    check("zero_errcnt", bus16.err_count,  16'd0);
    for (int i = 1; i <= 23; i++) send_bit(i, 1'b0);
    check("zero_lock_pre", 16'(bus16.locked), 16'd0);
    send_bit(24, 1'b0);
    check("zero_lock_at24", 16'(bus16.locked), 16'd1);

    // Reset in LOCKED, coincident with a mismatching valid bit.
    for (int i = 25; i <= 40; i++) send_bit(i, 1'b0);
    send_bit(41, 1'b1);
    check("pre_rst_errcnt", bus16.err_count, 16'd1);
    reset = 1'b1;
    send(~s[42], 1'b1, 1'b0);
    check("midrst_locked",    16'(bus16.locked),    16'd0);
    check("midrst_err_pulse", 16'(bus16.err_pulse), 16'd0);
    check("midrst_errcnt",    bus16.err_count,      16'd0);
    check("midrst_err_w2",    16'(bus2.err_count),  16'd0);
    reset = 1'b0;

    // Reacquire with random valid gaps; gaps must not disturb match counting.
    vn = 1;
    iters = 0;
    early = 0;
    while (vn <= 24 && iters < 2000) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        send(s[vn], 1'b1, 1'b0);
        vn++;
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      iters++;
      if (vn <= 24 && bus16.locked) early++;
    end
    check("gap_budget",  16'(vn),            16'd25);
    check("gap_early",   16'(early),         16'd0);
    check("gap_locked",  16'(bus16.locked),  16'd1);
    send(~s[25], 1'b0, 1'b0);
    check("gap_hold_locked", 16'(bus16.locked),    16'd1);
    check("gap_hold_pulse",  16'(bus16.err_pulse), 16'd0);
    send_bit(25, 1'b0);
    check("gap_next_pulse",  16'(bus16.err_pulse), 16'd0);
    check("gap_next_errcnt", bus16.err_count,      16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
